// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze navigation controller and its helpers.
//   - cmd_op_e    : command opcodes on cmd_op
//   - heading_e   : 2-bit heading taken from the top bits of the view angle
//   - nav_state_e : navigation FSM states
//   - hor_idx / ver_idx : flat bit index into the wall bitmaps
// -----------------------------------------------------------------------------
package maze_pkg;

  typedef enum logic [1:0] {
    OP_FWD  = 2'b00,
    OP_BACK = 2'b01,
    OP_ROTL = 2'b10,  // counter-clockwise, angle increases
    OP_ROTR = 2'b11   // clockwise, angle decreases
  } cmd_op_e;

  // Heading decode of angle[ANGLE_W-1 -: 2]. The opposite heading differs
  // only in the MSB, which is how a BACK move is turned into a direction.
  typedef enum logic [1:0] {
    HEAD_E = 2'b00,  // +x
    HEAD_N = 2'b01,  // -y
    HEAD_W = 2'b10,  // -x
    HEAD_S = 2'b11   // +y
  } heading_e;

  typedef enum logic [1:0] {
    STILL    = 2'b00,
    CHECK    = 2'b01,
    INIT_CAM = 2'b10,
    DRAW     = 2'b11
  } nav_state_e;

  // Bit of HOR_WALL holding the wall on the north edge of cell (x,y).
  function automatic int hor_idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

  // Bit of VER_WALL holding the wall on the west edge of cell (x,y).
  function automatic int ver_idx(input int x, input int y, input int w);
    return y * (w + 1) + x;
  endfunction

endpackage

// File: rtl/maze_wall_check.sv
// -----------------------------------------------------------------------------
// maze_wall_check
// Combinational move legality check for one step from cell (x,y).
// Parameters : MAZE_W, MAZE_H, HOR_WALL, VER_WALL (same meaning as the top).
// Inputs     : x, y     - current cell
//              heading  - facing direction (heading_e encoding)
//              back     - 1 = step opposite to the heading
// Outputs    : blocked  - step leaves the grid or crosses a wall
//              tx, ty   - target cell; equals (x,y) when the step would
//                         leave the grid
// -----------------------------------------------------------------------------
module maze_wall_check
  import maze_pkg::*;
#(
  parameter int MAZE_W = 5,
  parameter int MAZE_H = 5,
  parameter logic [(MAZE_H+1)*MAZE_W-1:0] HOR_WALL =
    {{MAZE_W{1'b1}}, {((MAZE_H-1)*MAZE_W){1'b0}}, {MAZE_W{1'b1}}},
  parameter logic [MAZE_H*(MAZE_W+1)-1:0] VER_WALL =
    {MAZE_H{{1'b1, {(MAZE_W-1){1'b0}}, 1'b1}}}
) (
  input  logic [$clog2(MAZE_W)-1:0] x,
  input  logic [$clog2(MAZE_H)-1:0] y,
  input  logic [1:0]                heading,
  input  logic                      back,
  output logic                      blocked,
  output logic [$clog2(MAZE_W)-1:0] tx,
  output logic [$clog2(MAZE_H)-1:0] ty
);

  localparam int XW  = $clog2(MAZE_W);
  localparam int YW  = $clog2(MAZE_H);
  localparam int HIW = $clog2((MAZE_H+1)*MAZE_W);
  localparam int VIW = $clog2(MAZE_H*(MAZE_W+1));

  localparam logic [XW-1:0] X_MAX = XW'(MAZE_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAZE_H - 1);

  logic [1:0]     dir;
  logic           in_grid;
  logic [HIW-1:0] n_idx;
  logic [HIW-1:0] s_idx;
  logic [VIW-1:0] w_idx;
  logic [VIW-1:0] e_idx;

  // Reversing a heading flips its MSB (E<->W, N<->S).
  assign dir     = {heading[1] ^ back, heading[0]};
  assign in_grid = (x <= X_MAX) && (y <= Y_MAX);

  // Edge indices of the four sides of the current cell. They are only
  // consulted after the bounds test has passed, so every selected bit lies
  // inside the bitmap.
  assign n_idx = HIW'(hor_idx(int'(x), int'(y), MAZE_W));
  assign s_idx = HIW'(hor_idx(int'(x), int'(y) + 1, MAZE_W));
  assign w_idx = VIW'(ver_idx(int'(x), int'(y), MAZE_W));
  assign e_idx = VIW'(ver_idx(int'(x) + 1, int'(y), MAZE_W));

  always_comb begin
    blocked = 1'b1;
    tx      = x;
    ty      = y;
    if (in_grid) begin
      unique case (heading_e'(dir))
        HEAD_E: begin
          if (x != X_MAX) begin
            blocked = VER_WALL[e_idx];
            tx      = x + 1'b1;
          end
        end
        HEAD_N: begin
          if (y != '0) begin
            blocked = HOR_WALL[n_idx];
            ty      = y - 1'b1;
          end
        end
        HEAD_W: begin
          if (x != '0) begin
            blocked = VER_WALL[w_idx];
            tx      = x - 1'b1;
          end
        end
        HEAD_S: begin
          if (y != Y_MAX) begin
            blocked = HOR_WALL[s_idx];
            ty      = y + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/maze_nav_ctrl.sv
// -----------------------------------------------------------------------------
// maze_nav_ctrl
// Player navigation controller for the maze renderer. Accepts move/rotate
// commands, checks moves against the grid bounds and wall bitmaps, updates
// the player cell and view angle, then asks the ray-cast pipeline for a
// new frame (cam_load / draw_done).
//
// Optional build macro: MAZE_GOAL_DETECT_EN
//   Adds parameters GOAL_X/GOAL_Y and output goal_reached. Once the player
//   stands on the goal cell the flag stays set until rst and every later
//   move is rejected with a bump; rotates still work.
//
// Ports:
//   clk_in     in   system clock
//   rst        in   synchronous reset, active-high
//   cmd_valid  in   command offered
//   cmd_ready  out  controller can accept a command (high only in STILL)
//   cmd_op     in   00 forward, 01 back, 10 rotate left, 11 rotate right
//   pos_x      out  current column
//   pos_y      out  current row
//   angle      out  current view angle, full turn = 2^ANGLE_W
//   cam_load   out  one-cycle pulse: renderer latches pos/angle, starts frame
//   draw_done  in   renderer frame-complete pulse (looked at only in DRAW)
//   busy       out  high whenever the FSM is not in STILL
//   bump       out  one-cycle pulse: move rejected
//   goal_reached out  (MAZE_GOAL_DETECT_EN only) sticky goal flag
//   state_dbg  out  current FSM state
//
// Handshake: a command transfers on a rising clk_in edge where cmd_valid and
// cmd_ready are both high. cmd_ready is registered and only high in STILL,
// so nothing is queued while busy; cmd_valid may stay high and is simply
// taken at the first edge back in STILL.
//
// Timing from the accept cycle (cycle 0): cycle 1 is CHECK; in cycle 2 the
// new pos/angle is visible together with either the cam_load pulse (legal
// move, rotate) or the bump pulse and cmd_ready (rejected move).
// -----------------------------------------------------------------------------
module maze_nav_ctrl
  import maze_pkg::*;
#(
  parameter int MAZE_W = 5,
  parameter int MAZE_H = 5,
  parameter logic [(MAZE_H+1)*MAZE_W-1:0] HOR_WALL =
    {{MAZE_W{1'b1}}, {((MAZE_H-1)*MAZE_W){1'b0}}, {MAZE_W{1'b1}}},
  parameter logic [MAZE_H*(MAZE_W+1)-1:0] VER_WALL =
    {MAZE_H{{1'b1, {(MAZE_W-1){1'b0}}, 1'b1}}},
  parameter int ANGLE_W     = 8,
  parameter int ROT_STEP    = 64,
  parameter int START_X     = 0,
  parameter int START_Y     = 0,
  parameter int START_ANGLE = 0
`ifdef MAZE_GOAL_DETECT_EN
  ,
  parameter int GOAL_X      = MAZE_W - 1,
  parameter int GOAL_Y      = MAZE_H - 1
`endif
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  output logic [$clog2(MAZE_W)-1:0] pos_x,
  output logic [$clog2(MAZE_H)-1:0] pos_y,
  output logic [ANGLE_W-1:0]        angle,
  output logic                      cam_load,
  input  logic                      draw_done,
  output logic                      busy,
  output logic                      bump,
`ifdef MAZE_GOAL_DETECT_EN
  output logic                      goal_reached,
`endif
  output nav_state_e                state_dbg
);

  localparam int XW = $clog2(MAZE_W);
  localparam int YW = $clog2(MAZE_H);

  localparam logic [XW-1:0]      START_XV = XW'(START_X);
  localparam logic [YW-1:0]      START_YV = YW'(START_Y);
  localparam logic [ANGLE_W-1:0] START_AV = ANGLE_W'(START_ANGLE);
  localparam logic [ANGLE_W-1:0] ROT_V    = ANGLE_W'(ROT_STEP);

`ifdef MAZE_GOAL_DETECT_EN
  localparam logic [XW-1:0] GOAL_XV     = XW'(GOAL_X);
  localparam logic [YW-1:0] GOAL_YV     = YW'(GOAL_Y);
  localparam logic          START_GOAL  = (START_XV == GOAL_XV) && (START_YV == GOAL_YV);
`endif

  nav_state_e state;
  nav_state_e next_state;
  cmd_op_e    op_q;

  logic              accept;
  logic              is_rot;
  logic              wc_blocked;
  logic              move_blocked;
  logic [XW-1:0]     tx;
  logic [YW-1:0]     ty;

  // Next values of the registered outputs, produced by the output process.
  logic              ready_d;
  logic              cam_d;
  logic              bump_d;
  logic              pos_upd;
  logic [ANGLE_W-1:0] angle_d;

  assign accept = cmd_valid & cmd_ready;
  assign is_rot = (op_q == OP_ROTL) || (op_q == OP_ROTR);

  maze_wall_check #(
    .MAZE_W   (MAZE_W),
    .MAZE_H   (MAZE_H),
    .HOR_WALL (HOR_WALL),
    .VER_WALL (VER_WALL)
  ) u_wall_check (
    .x       (pos_x),
    .y       (pos_y),
    .heading (angle[ANGLE_W-1 -: 2]),
    .back    (op_q == OP_BACK),
    .blocked (wc_blocked),
    .tx      (tx),
    .ty      (ty)
  );

`ifdef MAZE_GOAL_DETECT_EN
  assign move_blocked = wc_blocked | goal_reached;
`else
  assign move_blocked = wc_blocked;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= INIT_CAM;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // INIT_CAM is left only once cam_load has actually been high. After reset
  // the state is INIT_CAM with cam_load still low, so the first post-reset
  // cycle spends one extra INIT_CAM cycle to raise the pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      STILL:    if (accept) next_state = CHECK;
      CHECK:    next_state = (is_rot || !move_blocked) ? INIT_CAM : STILL;
      INIT_CAM: if (cam_load) next_state = DRAW;
      DRAW:     if (draw_done) next_state = STILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d = (next_state == STILL);
    cam_d   = (next_state == INIT_CAM);
    bump_d  = 1'b0;
    pos_upd = 1'b0;
    angle_d = angle;
    if (state == CHECK) begin
      unique case (op_q)
        OP_ROTL: angle_d = angle + ROT_V;
        OP_ROTR: angle_d = angle - ROT_V;
        OP_FWD, OP_BACK: begin
          bump_d  = move_blocked;
          pos_upd = !move_blocked;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and command capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      op_q      <= OP_FWD;
      pos_x     <= START_XV;
      pos_y     <= START_YV;
      angle     <= START_AV;
      cmd_ready <= 1'b0;
      cam_load  <= 1'b0;
      bump      <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= cmd_op_e'(cmd_op);
      end
      if (pos_upd) begin
        pos_x <= tx;
        pos_y <= ty;
      end
      angle     <= angle_d;
      cmd_ready <= ready_d;
      cam_load  <= cam_d;
      bump      <= bump_d;
    end
  end

`ifdef MAZE_GOAL_DETECT_EN
  always_ff @(posedge clk_in) begin
    if (rst) begin
      goal_reached <= START_GOAL;
    end else if (pos_upd && (tx == GOAL_XV) && (ty == GOAL_YV)) begin
      goal_reached <= 1'b1;
    end
  end
`endif

  assign busy      = (state != STILL);
  assign state_dbg = state;

endmodule

// File: tb/tb_maze_nav_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_nav_ctrl
// Directed bench for maze_nav_ctrl. Unit 0 uses the default open maze;
// unit 1 adds a wall on the east edge of cell (0,0) (VER_WALL bit 1).
// -----------------------------------------------------------------------------
module tb_maze_nav_ctrl;
  import maze_pkg::*;

  localparam logic [29:0] VW_UNIT1 = {5{6'b100001}} | 30'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_op    [2];
  logic [2:0] pos_x     [2];
  logic [2:0] pos_y     [2];
  logic [7:0] angle     [2];
  logic       cam_load  [2];
  logic       draw_done [2];
  logic       busy      [2];
  logic       bump      [2];
  nav_state_e state_dbg [2];

  maze_nav_ctrl dut0 (
    .clk_in    (clk),
    .rst       (rst[0]),
    .cmd_valid (cmd_valid[0]),
    .cmd_ready (cmd_ready[0]),
    .cmd_op    (cmd_op[0]),
    .pos_x     (pos_x[0]),
    .pos_y     (pos_y[0]),
    .angle     (angle[0]),
    .cam_load  (cam_load[0]),
    .draw_done (draw_done[0]),
    .busy      (busy[0]),
    .bump      (bump[0]),
    .state_dbg (state_dbg[0])
  );

  maze_nav_ctrl #(.VER_WALL(VW_UNIT1)) dut1 (
    .clk_in    (clk),
    .rst       (rst[1]),
    .cmd_valid (cmd_valid[1]),
    .cmd_ready (cmd_ready[1]),
    .cmd_op    (cmd_op[1]),
    .pos_x     (pos_x[1]),
    .pos_y     (pos_y[1]),
    .angle     (angle[1]),
    .cam_load  (cam_load[1]),
    .draw_done (draw_done[1]),
    .busy      (busy[1]),
    .bump      (bump[1]),
    .state_dbg (state_dbg[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change and outputs are sampled 1ns after posedge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int u);
    rst[u] = 1'b1;
    tick();
    tick();
    check("rst_pos_x", pos_x[u], 0);
    check("rst_pos_y", pos_y[u], 0);
    check("rst_angle", angle[u], 0);
    check("rst_cam_load", cam_load[u], 0);
    check("rst_bump", bump[u], 0);
    check("rst_ready", cmd_ready[u], 0);
    check("rst_busy", busy[u], 1);
    check("rst_state", 32'(state_dbg[u]), 32'(INIT_CAM));
    rst[u] = 1'b0;
    tick();
    check("init_cam_load", cam_load[u], 1);
    check("init_busy", busy[u], 1);
    tick();
    check("init_cam_off", cam_load[u], 0);
    check("init_draw_ready", cmd_ready[u], 0);
    draw_done[u] = 1'b1;
    tick();
    draw_done[u] = 1'b0;
    check("init_ready", cmd_ready[u], 1);
    check("init_idle", busy[u], 0);
  endtask

  // Waits (bounded) for cmd_ready, transfers one command, returns in CHECK.
  task automatic issue(input int u, input cmd_op_e op);
    int n;
    n = 0;
    while (cmd_ready[u] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_cmd", cmd_ready[u], 1);
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = op;
    tick();
    cmd_valid[u] = 1'b0;
    check("check_state", 32'(state_dbg[u]), 32'(CHECK));
    check("check_no_cam", cam_load[u], 0);
  endtask

  // From INIT_CAM: step to DRAW, return draw_done, back in STILL.
  task automatic finish_frame(input int u);
    tick();
    check("draw_state", 32'(state_dbg[u]), 32'(DRAW));
    draw_done[u] = 1'b1;
    tick();
    draw_done[u] = 1'b0;
    check("frame_ready", cmd_ready[u], 1);
  endtask

  task automatic rot_check(input int u, input cmd_op_e op, input logic [7:0] exp_a);
    issue(u, op);
    tick();
    check("rot_angle", angle[u], exp_a);
    check("rot_cam_load", cam_load[u], 1);
    check("rot_bump", bump[u], 0);
    finish_frame(u);
  endtask

  task automatic move_check(input int u, input cmd_op_e op, input logic [2:0] ex,
                            input logic [2:0] ey, input logic blk);
    issue(u, op);
    tick();
    check("move_pos_x", pos_x[u], ex);
    check("move_pos_y", pos_y[u], ey);
    check("move_bump", bump[u], blk);
    check("move_cam_load", cam_load[u], !blk);
    check("move_ready", cmd_ready[u], blk);
    if (blk) begin
      tick();
      check("bump_pulse_end", bump[u], 0);
      check("bump_no_cam", cam_load[u], 0);
    end else begin
      finish_frame(u);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      cmd_valid[i] = 1'b0;
      cmd_op[i]    = 2'b00;
      draw_done[i] = 1'b0;
    end

    // ---- unit 0: open maze ----
    do_reset(0);

    exp_q.push_back(8'd64);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd192);
    exp_q.push_back(8'd0);
    while (exp_q.size() > 0) rot_check(0, OP_ROTL, exp_q.pop_front());
    rot_check(0, OP_ROTR, 8'd192);
    rot_check(0, OP_ROTL, 8'd0);

    move_check(0, OP_FWD,  3'd1, 3'd0, 1'b0);  // east into open cell
    move_check(0, OP_BACK, 3'd0, 3'd0, 1'b0);  // back = west
    rot_check(0, OP_ROTL, 8'd64);
    move_check(0, OP_FWD,  3'd0, 3'd0, 1'b1);  // north off the grid
    rot_check(0, OP_ROTL, 8'd128);
    move_check(0, OP_FWD,  3'd0, 3'd0, 1'b1);  // west off the grid
    move_check(0, OP_BACK, 3'd1, 3'd0, 1'b0);  // back while facing west = east
    rot_check(0, OP_ROTL, 8'd192);
    move_check(0, OP_FWD,  3'd1, 3'd1, 1'b0);  // south
    move_check(0, OP_BACK, 3'd1, 3'd0, 1'b0);  // back while facing south = north
    rot_check(0, OP_ROTL, 8'd0);
    for (int k = 2; k <= 4; k++) move_check(0, OP_FWD, 3'(k), 3'd0, 1'b0);
    move_check(0, OP_FWD,  3'd4, 3'd0, 1'b1);  // east border at x=4

    // cmd_valid held through the whole frame: exactly one rotate per frame.
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = OP_ROTL;
    tick();
    check("hold_check", 32'(state_dbg[0]), 32'(CHECK));
    tick();
    check("hold_angle1", angle[0], 64);
    tick();
    for (int k = 0; k < 3; k++) tick();
    check("hold_draw", 32'(state_dbg[0]), 32'(DRAW));
    check("hold_not_ready", cmd_ready[0], 0);
    check("hold_angle_kept", angle[0], 64);
    draw_done[0] = 1'b1;
    tick();
    draw_done[0] = 1'b0;
    check("hold_ready", cmd_ready[0], 1);
    tick();
    cmd_valid[0] = 1'b0;
    check("hold_second_accept", 32'(state_dbg[0]), 32'(CHECK));
    tick();
    check("hold_angle2", angle[0], 128);
    finish_frame(0);

    // Stray draw_done while idle.
    draw_done[0] = 1'b1;
    tick();
    tick();
    draw_done[0] = 1'b0;
    check("stray_ready", cmd_ready[0], 1);
    check("stray_busy", busy[0], 0);
    check("stray_cam", cam_load[0], 0);
    check("stray_angle", angle[0], 128);

    // Reset in the middle of a frame.
    issue(0, OP_FWD);
    tick();
    check("mid_pos_x", pos_x[0], 3);
    tick();
    check("mid_draw", 32'(state_dbg[0]), 32'(DRAW));
    do_reset(0);

    // ---- unit 1: wall on the east edge of (0,0) ----
    do_reset(1);
    move_check(1, OP_FWD,  3'd0, 3'd0, 1'b1);  // wall east of (0,0)
    rot_check(1, OP_ROTR, 8'd192);
    move_check(1, OP_FWD,  3'd0, 3'd1, 1'b0);
    rot_check(1, OP_ROTL, 8'd0);
    move_check(1, OP_FWD,  3'd1, 3'd1, 1'b0);
    rot_check(1, OP_ROTL, 8'd64);
    move_check(1, OP_FWD,  3'd1, 3'd0, 1'b0);
    rot_check(1, OP_ROTR, 8'd0);
    move_check(1, OP_BACK, 3'd1, 3'd0, 1'b1);  // same wall from the other side
    move_check(1, OP_FWD,  3'd2, 3'd0, 1'b0);  // neighbouring edge is open

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
